// File: rtl/case_2_acc_sat_11s_16_pkg.sv
// Shared types and limits for the saturating frame accumulator.
// Saturation rails are derived from the accumulator width.
package case_2_acc_sat_11s_16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/case_2_acc_sat_11s_16_sat_add.sv
// Combinational sign-extend, add and clamp to the accumulator rails; no latency, no backpressure.
// sat_o flags any step where the clamp engaged.
module case_2_sat_add
  import case_2_acc_sat_11s_16_pkg::*;
#(
  parameter int DIN_WIDTH = 11,
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [DIN_WIDTH-1:0] din_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 sat_o
);

  localparam logic signed [ACC_WIDTH:0] SUM_MAX = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0] SUM_MIN = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] din_ext;
  logic signed [ACC_WIDTH:0] sum;

  always_comb begin
    acc_ext = {acc_i[ACC_WIDTH-1], acc_i};
    din_ext = (ACC_WIDTH+1)'($signed(din_i));
    sum     = acc_ext + din_ext;
    sat_o   = 1'b0;
    sum_o   = sum[ACC_WIDTH-1:0];
    if (sum > SUM_MAX) begin
      sum_o = SUM_MAX[ACC_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (sum < SUM_MIN) begin
      sum_o = SUM_MIN[ACC_WIDTH-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/case_2_acc_sat_11s_16.sv
// Frame accumulator: sums signed beats with per-step saturation, result valid 1 cycle after the last beat.
// in_ready drops while a result is held; the result stays stable until out_ready.
module case_2_acc_sat_11s_16
  import case_2_acc_sat_11s_16_pkg::*;
#(
  parameter int DIN_WIDTH = 11,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [DIN_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] odata_q, odata_d;
  logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;
  logic                 osat_q, osat_d;
  logic                 rdy_en_q;
  logic [ACC_WIDTH-1:0] add_acc, add_sum;
  logic                 add_hit;
  logic                 xfer;

  // rdy_en_q keeps in_ready low until the first clock after reset release
  assign in_ready  = rdy_en_q && (state_q != OUT);
  assign xfer      = in_valid && in_ready;
  assign out_valid = (state_q == OUT);
  assign out_data  = odata_q;
  assign out_count = ocnt_q;
  assign out_sat   = osat_q;
  assign add_acc   = (state_q == IDLE) ? '0 : acc_q;

  case_2_sat_add #(
    .DIN_WIDTH(DIN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_add (
    .acc_i(add_acc),
    .din_i(in_data),
    .sum_o(add_sum),
    .sat_o(add_hit)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    odata_d = odata_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          acc_d   = add_sum;
          cnt_d   = CNT_WIDTH'(1);
          sat_d   = 1'b0;
          state_d = in_last ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d = add_sum;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
          sat_d = sat_q | add_hit;
          if (in_last) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Capture the result only when the closing beat lands
    if (xfer && in_last) begin
      odata_d = acc_d;
      ocnt_d  = cnt_d;
      osat_d  = sat_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      odata_q  <= '0;
      ocnt_q   <= '0;
      osat_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      odata_q  <= odata_d;
      ocnt_q   <= ocnt_d;
      osat_q   <= osat_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_case_2_acc_sat_11s_16.sv
// Directed and randomized frames checked against a plain-integer saturating-sum model.
module tb_case_2_acc_sat_11s_16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  case_2_acc_sat_11s_16 dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_count(out_count),
    .out_sat(out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sdata();
    logic signed [15:0] v;
    v = out_data;
    return 32'(v);
  endfunction

  // Reference: running sum clamped to 16-bit rails after every beat, count capped at 255
  function automatic void ref_frame(input int vals[$], output int s, output int c, output int f);
    s = 0; c = 0; f = 0;
    foreach (vals[i]) begin
      if (i == 0) begin
        s = vals[i]; c = 1;
      end else begin
        s = s + vals[i];
        if (s > 32767) begin s = 32767; f = 1; end
        else if (s < -32768) begin s = -32768; f = 1; end
        c = (c < 255) ? c + 1 : 255;
      end
    end
  endfunction

  task automatic beat(input int d, input bit last);
    int guard;
    guard = 0;
    in_data = d[10:0]; in_valid = 1'b1; in_last = last;
    while (!in_ready && guard < 100) begin
      @(posedge ap_clk); #1; guard++;
    end
    if (guard >= 100) chk("ready_timeout", 0, 1);
    @(posedge ap_clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_last = 1'($urandom);
    in_data = 11'($urandom);
    repeat (n) begin @(posedge ap_clk); #1; end
    in_last = 1'b0;
  endtask

  task automatic run_frame(input int vals[$], input int hold, input bit gaps);
    int s, c, f;
    ref_frame(vals, s, c, f);
    foreach (vals[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) gap($urandom_range(1, 2));
      beat(vals[i], i == vals.size() - 1);
    end
    chk("valid_latency", 32'(out_valid), 1);
    chk("data", sdata(), s);
    chk("count", 32'(out_count), c);
    chk("sat", 32'(out_sat), f);
    chk("ready_in_out", 32'(in_ready), 0);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'b1; in_data = 11'($urandom); in_last = 1'($urandom);
      @(posedge ap_clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", sdata(), s);
      chk("hold_count", 32'(out_count), c);
      chk("hold_ready", 32'(in_ready), 0);
    end
    // A beat offered in the consume cycle must not be taken
    in_valid = 1'b1; in_data = 11'd300; in_last = 1'b1; out_ready = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 0);
    chk("consume_ready", 32'(in_ready), 1);
    chk("idle_hold_data", sdata(), s);
    chk("idle_hold_sat", 32'(out_sat), f);
  endtask

  initial begin
    int q[$];
    ap_rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_data", sdata(), 0);
    chk("rst_count", 32'(out_count), 0);
    ap_rst_n = 1'b1;
    #1;
    chk("ready_before_clk", 32'(in_ready), 0);
    @(posedge ap_clk); #1;
    chk("ready_after_clk", 32'(in_ready), 1);

    q = {100, -20, 5};
    run_frame(q, 0, 1'b0);

    q = {};
    for (int i = 0; i < 40; i++) q.push_back(1023);
    run_frame(q, 1, 1'b0);

    q = {};
    for (int i = 0; i < 40; i++) q.push_back(-1024);
    q.push_back(1000);
    run_frame(q, 0, 1'b0);
    chk("neg_rail_recover", sdata(), -31768);

    q = {-7};
    run_frame(q, 5, 1'b0);

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(1);
    run_frame(q, 0, 1'b1);
    chk("count_cap", 32'(out_count), 255);

    // Reset mid-frame discards the partial sum and clears outputs at once
    beat(500, 1'b0);
    beat(600, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_data", sdata(), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    chk("mid_rst_sat", 32'(out_sat), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("mid_rst_no_result", 32'(out_valid), 0);
    q = {4, 4};
    run_frame(q, 0, 1'b0);

    for (int fr = 0; fr < 12; fr++) begin
      int len, mode, v;
      len = $urandom_range(1, 60);
      mode = $urandom_range(0, 2);
      q = {};
      for (int i = 0; i < len; i++) begin
        case (mode)
          1: v = $urandom_range(500, 1023);
          2: v = -int'($urandom_range(500, 1024));
          default: v = int'($urandom_range(0, 2047)) - 1024;
        endcase
        q.push_back(v);
      end
      run_frame(q, $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/case_2_acc_sat_11s_16.md
CASE_2_ACC_SAT_11S_16 -- requirements
Module: case_2_acc_sat_11s_16

Interface
REQ-001 Parameter DIN_WIDTH, default 11: width of the signed product input; matches the 11-bit signed multiplier output.
REQ-002 Parameter ACC_WIDTH, default 16: width of the signed accumulator and result.
REQ-003 Parameter CNT_WIDTH, default 8: width of the beat counter.
REQ-004 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_data  in  DIN_WIDTH  signed product from the upstream multiplier.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_last  in  1  marks the final beat of a frame; qualified by in_valid.
REQ-009 in_ready  out  1  block accepts a beat this cycle.
REQ-010 out_data  out  ACC_WIDTH  saturated signed frame sum.
REQ-011 out_count  out  CNT_WIDTH  beats accepted in the frame.
REQ-012 out_sat  out  1  any saturation occurred in the frame.
REQ-013 out_valid  out  1  out_data, out_count and out_sat valid.
REQ-014 out_ready  in  1  downstream accepts the result.

Function
REQ-015 An input beat SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-016 The FSM SHALL have three states: IDLE (no frame open), ACCUM (frame open), OUT (result held).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in OUT.
REQ-018 A transfer in IDLE SHALL load acc = sat(sext(in_data)), count = 1, sat_flag = 0, and go to ACCUM; if in_last is 1, it SHALL go to OUT instead.
REQ-019 A transfer in ACCUM SHALL set acc = sat(acc + sext(in_data)), computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-020 A transfer in ACCUM SHALL increment count; count SHALL saturate at 2^CNT_WIDTH-1 and not wrap.
REQ-021 sat_flag SHALL become 1 on any clamping step and SHALL stay 1 until the frame is consumed.
REQ-022 Saturation SHALL apply per step: after a clamp, later opposite-sign beats move acc away from the rail.
REQ-023 A transfer with in_last=1 SHALL go to OUT, with out_valid=1 in the next cycle (latency 1 cycle from the last beat).
REQ-024 In OUT, out_data, out_count and out_sat SHALL equal the final acc, count and sat_flag, and SHALL stay stable while out_ready=0.
REQ-025 In OUT, when out_ready=1, the block SHALL return to IDLE with out_valid=0 in the next cycle.
REQ-026 A new frame's first beat SHALL NOT be accepted in the same cycle the result is consumed (no bypass).
REQ-027 In OUT, in_valid and in_data SHALL be ignored.
REQ-028 in_last without in_valid SHALL have no effect.
REQ-029 Outside OUT, out_valid SHALL be 0, and out_data, out_count and out_sat SHALL hold their last values.

Reset
REQ-030 Asserting ap_rst_n low SHALL immediately force state=IDLE, acc=0, count=0, sat_flag=0, out_valid=0, in_ready=0, out_data=0, out_count=0 and out_sat=0.
REQ-031 in_ready SHALL rise in the first ap_clk cycle after reset deassertion.
REQ-032 Reset during ACCUM or OUT SHALL discard the partial frame or pending result, with no output produced.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (IDLE, ACCUM, OUT) and the saturation limits as functions of ACC_WIDTH.
REQ-034 A single sub-module, case_2_sat_add, SHALL implement the combinational sign-extend, add and clamp, with a saturation-hit output.
REQ-035 All other logic (FSM, counter, output registers) SHALL reside in the top module.

Verification
REQ-036 Frame 100, -20, 5(last) with out_ready=1 -> out_data=85, out_count=3, out_sat=0, out_valid one cycle after the last beat.
REQ-037 Forty beats of 1023 (last on the 40th) -> clamp on the 33rd beat; out_data=32767, out_count=40, out_sat=1.
REQ-038 Forty beats of -1024, then a 41st beat of +1000 (last) -> out_data=-31768, out_count=41, out_sat=1.
REQ-039 Single beat -7 with last, out_ready held 0 for 5 cycles -> out_data=-7 and out_count=1 stable, in_ready=0, in_valid beats ignored; result consumed on the 6th cycle, then IDLE.
REQ-040 300 beats of 1 (last on the 300th) -> out_count=255, out_data=300, out_sat=0.
REQ-041 ap_rst_n pulsed low after 2 beats of a frame -> outputs zero asynchronously, no result emitted; the following frame 4, 4(last) -> out_data=8, out_count=2.
